// File: rtl/tone_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : tone_burst_if
// Purpose  : Command/status bundle for the tone burst sequencer. The master
//            side issues commands and abort; the slave side reports status
//            and the generated wave.
// Revision : 1.0 - initial release
// ============================================================================
interface tone_burst_if #(
  parameter int DEPTH     = 4,
  parameter int NBITS_DIV = 16,
  parameter int NBITS_CNT = 8
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [NBITS_DIV-1:0]         cmd_half;
  logic [NBITS_CNT-1:0]         cmd_count;
  logic                         abort;
  logic                         wave;
  logic                         done;
  logic                         busy;
  logic [$clog2(DEPTH+1)-1:0]   fifo_level;

  modport master (
    output cmd_valid, cmd_half, cmd_count, abort,
    input  cmd_ready, wave, done, busy, fifo_level
  );

  modport slave (
    input  cmd_valid, cmd_half, cmd_count, abort,
    output cmd_ready, wave, done, busy, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/tone_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_burst_sequencer
// Purpose  : Queues {half-period, period-count} tone commands in a small FIFO
//            and plays them back-to-back as a square wave, pulsing done once
//            per completed command. Abort flushes the queue and stops output.
// Revision : 1.0 - initial release
// ============================================================================
module tone_burst_sequencer #(
  parameter int DEPTH     = 4,
  parameter int NBITS_DIV = 16,
  parameter int NBITS_CNT = 8
) (
  input  logic         clk,
  input  logic         reset,
  tone_burst_if.slave  bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH + 1);

  localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_LVL_W-1:0]   c_LVL_ONE = c_LVL_W'(1);
  localparam logic [c_LVL_W-1:0]   c_FULL    = c_LVL_W'(DEPTH);
  localparam logic [NBITS_DIV-1:0] c_DIV_ONE = NBITS_DIV'(1);
  localparam logic [NBITS_CNT-1:0] c_CNT_ONE = NBITS_CNT'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [NBITS_DIV-1:0] r_mem_half [DEPTH];
  logic [NBITS_CNT-1:0] r_mem_cnt  [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_level;

  // Sequencer state
  state_t               r_state;
  logic [NBITS_DIV-1:0] r_half;
  logic [NBITS_CNT-1:0] r_count;
  logic [NBITS_DIV-1:0] r_div_cnt;
  logic [NBITS_CNT-1:0] r_remaining;
  logic                 r_wave;
  logic                 r_done;

  logic w_full;
  logic w_not_empty;
  logic w_ready;
  logic w_push;
  logic w_zero;
  logic w_period_end;
  logic w_last_low;
  logic w_pop;

  assign w_full       = (r_level == c_FULL);
  assign w_not_empty  = (r_level != '0);
  assign w_ready      = !w_full && !bus.abort;
  assign w_push       = bus.cmd_valid && w_ready;
  assign w_zero       = (r_half == '0) || (r_count == '0);
  assign w_period_end = (r_div_cnt == (r_half - c_DIV_ONE));
  // End of the final low phase of the burst being played
  assign w_last_low   = w_period_end && !r_wave && (r_remaining == c_CNT_ONE);

  // The FSM takes the next command whenever it is free to start one
  assign w_pop = !bus.abort && w_not_empty &&
                 ((r_state == S_IDLE) ||
                  ((r_state == S_LOAD) && w_zero) ||
                  ((r_state == S_RUN) && w_last_low));

  // Command storage write; contents need no reset since level guards reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_half[r_wr_ptr] <= bus.cmd_half;
      r_mem_cnt[r_wr_ptr]  <= bus.cmd_count;
    end
  end

  // FIFO pointers and occupancy; abort empties the queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sequencing FSM with registered wave and done outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_half      <= '0;
      r_count     <= '0;
      r_div_cnt   <= '0;
      r_remaining <= '0;
      r_wave      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.abort) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_wave    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_half  <= r_mem_half[r_rd_ptr];
        r_count <= r_mem_cnt[r_rd_ptr];
      end
      case (r_state)
        S_IDLE: begin
          r_wave <= 1'b0;
          if (w_pop) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_zero) begin
            // Zero-length command completes immediately without output
            r_done  <= 1'b1;
            r_state <= w_pop ? S_LOAD : S_IDLE;
          end else begin
            r_state     <= S_RUN;
            r_wave      <= 1'b1;
            r_div_cnt   <= '0;
            r_remaining <= r_count;
          end
        end
        S_RUN: begin
          if (w_period_end) begin
            r_div_cnt <= '0;
            if (r_wave) begin
              r_wave <= 1'b0;
            end else if (r_remaining > c_CNT_ONE) begin
              r_remaining <= r_remaining - c_CNT_ONE;
              r_wave      <= 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_state <= w_pop ? S_LOAD : S_IDLE;
            end
          end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wave  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = w_ready;
  assign bus.wave       = r_wave;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != S_IDLE) || w_not_empty;
  assign bus.fifo_level = r_level;

endmodule
`default_nettype wire

// File: doc/tone_burst_sequencer.md
# tone_burst_sequencer

Command-driven controller for the square-wave divider datapath: queues tone bursts, each given as a half-period in clock cycles and a number of output periods, and plays them back-to-back on a single `wave` output. It replaces fixed-parameter divider instances wherever firmware or upstream logic must change frequency and duration at run time. It holds a command FIFO, a sequencing FSM, the divide counter and the period counter, and reports completion per command.

## Interface
- `DEPTH`, 4, command FIFO depth; power of two, ≥ 2.
- `NBITS_DIV`, 16, width of the half-period field.
- `NBITS_CNT`, 8, width of the period-count field.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command; combinational `!full && !abort`.
- `cmd_half`  in  NBITS_DIV  half-period in clk cycles.
- `cmd_count`  in  NBITS_CNT  number of full output periods.
- `abort`  in  1  synchronous flush-and-stop.
- `wave`  out  1  square-wave output, registered.
- `done`  out  1  one-cycle pulse per completed command, registered.
- `busy`  out  1  `state != IDLE || fifo_level != 0`.
- `fifo_level`  out  $clog2(DEPTH+1)  number of queued commands.

## Operation
- Push: `cmd_valid && cmd_ready` at a rising edge writes {half, count} into the FIFO. A push to a full FIFO is impossible because `cmd_ready` is low. A pop in the same cycle does not reopen a full FIFO.
- FSM states:
  - IDLE: `wave` = 0. If the FIFO is non-empty, pop and go to LOAD.
  - LOAD: one cycle; latches the popped command.
    - If half == 0 or count == 0, the command is zero-length: pulse `done`, then go to LOAD with a pop if the FIFO is non-empty, else to IDLE. `wave` stays 0.
    - Otherwise go to RUN with `wave` <= 1, `div_cnt` <= 0 and `remaining` <= count.
  - RUN: `div_cnt` increments each cycle. When `div_cnt == half-1`:
    - `div_cnt` <= 0.
    - If `wave` == 1: `wave` <= 0.
    - If `wave` == 0 and `remaining` > 1: `remaining` -= 1 and `wave` <= 1.
    - If `wave` == 0 and `remaining` == 1: `done` <= 1, `wave` stays 0, and the FSM goes to LOAD with a pop if the FIFO is non-empty, else to IDLE.
- Each period is exactly `half` cycles high followed by `half` cycles low. A burst lasts 2·half·count cycles.
- Back-to-back commands: the LOAD cycle stretches the last low phase of the previous burst by exactly 1 cycle. There are no other gaps.
- `done` is high for exactly one cycle per command, including zero-length commands. It is never asserted on abort.
- Abort takes priority over everything:
  - Next edge: FIFO flushed (level 0), state IDLE, `wave` 0, `div_cnt` 0, `done` 0.
  - A push presented in the abort cycle is dropped, because `cmd_ready` is low.
- Arithmetic: `div_cnt` is NBITS_DIV wide and `remaining` is NBITS_CNT wide; neither can overflow. The maximum half is 2^NBITS_DIV − 1.

## Timing
- Reset, asynchronous: state IDLE, FIFO empty, `wave` 0, `done` 0, `busy` 0, `fifo_level` 0, `cmd_ready` 1 (unless `abort` is high).
- Reset asserted mid-burst clears all of the above immediately. No `done` is issued.
- Latency: a command accepted at edge T into an empty FIFO with the FSM in IDLE is popped at T+1 (LOAD) and `wave` rises at T+2.
- `fifo_level` updates the edge after a push or pop.
- `busy` rises the cycle after the first accept. It falls in the cycle the FSM enters IDLE with an empty FIFO, which is the same cycle `done` is high.

## Test plan
- Single burst: push half=3, count=2 at edge T. `wave` is high on [T+2,T+5), low on [T+5,T+8), high on [T+8,T+11), low from T+11. `done` is high only in cycle T+14. `busy` is low from T+14.
- Zero-length: push half=0, count=5 at T. `wave` stays 0 and `done` pulses at T+2. Repeat with half=4, count=0 for the same result.
- Back-to-back: push {2,1} and {2,1} at T and T+1. `wave` is high on [T+2,T+4), low on [T+4,T+7), high on [T+7,T+9). `done` pulses at T+6 and T+11.
- Full FIFO: while RUN is executing {1000,10}, push 5 commands. Four are accepted, `fifo_level` is 4 and `cmd_ready` is 0. The fifth is held until a pop, then accepted.
- Abort mid-burst with 3 commands queued: on the next edge `wave` = 0, `fifo_level` = 0, `busy` = 0 and no `done`. A new command afterwards starts with standard latency.
- Asynchronous reset asserted mid-high phase: outputs take their reset values without waiting for a clock edge. After release, a new command behaves as in the single-burst test.
